// File: rtl/key_event_gen_if.sv
// Signal bundle between the debounced key source and key_event_gen.
// The master drives the key level and count clear; the slave (key_event_gen) returns events.
interface key_event_gen_if #(
   parameter int CNT_BITS = 8
) ();
   // No valid/ready pairing: key_in is a level sampled every cycle, and each event
   // output is a one-cycle pulse that the consumer must take in that cycle.
   logic                key_in;
   logic                count_clr;
   logic                press_pulse;
   logic                release_pulse;
   logic                click_pulse;
   logic                long_pulse;
   logic                repeat_pulse;
   logic                held;
   logic [CNT_BITS-1:0] press_count;
   logic [1:0]          dbg_state;

   modport master (
      output key_in, count_clr,
      input  press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse,
      input  held, press_count, dbg_state
   );

   modport slave (
      input  key_in, count_clr,
      output press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse,
      output held, press_count, dbg_state
   );
endinterface

// File: rtl/key_event_gen.sv
// Turns a debounced key level into registered one-cycle press/release/click/long/repeat
// pulses, a held level and a wrapping press counter.
module key_event_gen #(
   parameter int LONG_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int TMR_W         = 26,
   parameter int CNT_BITS      = 8
) (
   input  logic             clk,
   input  logic             reset,
   key_event_gen_if.slave   kif
);

   typedef enum logic [1:0] {
      LOCKOUT = 2'd0,
      IDLE    = 2'd1,
      SHORT   = 2'd2,
      LONG    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [TMR_W-1:0]    rep_cnt_q, rep_cnt_d;
   logic [CNT_BITS-1:0] press_count_q, press_count_d;
   logic                press_q, press_d;
   logic                release_q, release_d;
   logic                click_q, click_d;
   logic                long_q, long_d;
   logic                repeat_q, repeat_d;
   logic                held_q, held_d;
   logic [CNT_BITS-1:0] count_base;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= LOCKOUT;
         hold_cnt_q    <= '0;
         rep_cnt_q     <= '0;
         press_count_q <= '0;
         press_q       <= 1'b0;
         release_q     <= 1'b0;
         click_q       <= 1'b0;
         long_q        <= 1'b0;
         repeat_q      <= 1'b0;
         held_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         rep_cnt_q     <= rep_cnt_d;
         press_count_q <= press_count_d;
         press_q       <= press_d;
         release_q     <= release_d;
         click_q       <= click_d;
         long_q        <= long_d;
         repeat_q      <= repeat_d;
         held_q        <= held_d;
      end
   end

   // Clear is applied first so a press on the same edge lands at 1.
   assign count_base = kif.count_clr ? '0 : press_count_q;

   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      rep_cnt_d     = rep_cnt_q;
      press_count_d = count_base;
      press_d       = 1'b0;
      release_d     = 1'b0;
      click_d       = 1'b0;
      long_d        = 1'b0;
      repeat_d      = 1'b0;

      case (state_q)
         LOCKOUT: begin
            if (!kif.key_in) state_d = IDLE;
         end
         IDLE: begin
            if (kif.key_in) begin
               state_d       = SHORT;
               press_d       = 1'b1;
               hold_cnt_d    = '0;
               press_count_d = count_base + CNT_BITS'(1);
            end
         end
         SHORT: begin
            if (!kif.key_in) begin
               state_d   = IDLE;
               release_d = 1'b1;
               click_d   = 1'b1;
            end else if (hold_cnt_q == TMR_W'(LONG_CYCLES - 1)) begin
               state_d   = LONG;
               long_d    = 1'b1;
               rep_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + TMR_W'(1);
            end
         end
         LONG: begin
            if (!kif.key_in) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end else if (rep_cnt_q == TMR_W'(REPEAT_CYCLES - 1)) begin
               repeat_d  = 1'b1;
               rep_cnt_d = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + TMR_W'(1);
            end
         end
         default: state_d = LOCKOUT;
      endcase

      held_d = (state_d == SHORT) || (state_d == LONG);
   end

   assign kif.press_pulse   = press_q;
   assign kif.release_pulse = release_q;
   assign kif.click_pulse   = click_q;
   assign kif.long_pulse    = long_q;
   assign kif.repeat_pulse  = repeat_q;
   assign kif.held          = held_q;
   assign kif.press_count   = press_count_q;
   assign kif.dbg_state     = state_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with LONG_CYCLES=10, REPEAT_CYCLES=4, CNT_BITS=2.
module tb_key_event_gen;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;

   key_event_gen_if #(.CNT_BITS(2)) kif ();

   key_event_gen #(
      .LONG_CYCLES  (10),
      .REPEAT_CYCLES(4),
      .TMR_W        (8),
      .CNT_BITS     (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .kif  (kif.slave)
   );

   // {press, release, click, long, repeat, held}
   logic [5:0] obs;
   assign obs = {kif.press_pulse, kif.release_pulse, kif.click_pulse,
                 kif.long_pulse, kif.repeat_pulse, kif.held};

   localparam logic [5:0] P_PRESS = 6'b100000;
   localparam logic [5:0] P_REL   = 6'b010000;
   localparam logic [5:0] P_CLICK = 6'b001000;
   localparam logic [5:0] P_LONG  = 6'b000100;
   localparam logic [5:0] P_REP   = 6'b000010;
   localparam logic [5:0] P_HELD  = 6'b000001;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One sampled edge, then settle past it before anything is checked or driven.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [5:0] exp_v;
      reset = 1'b1;
      kif.key_in = 1'b1;
      kif.count_clr = 1'b0;
      step();
      step();
      n_cmp++;
      if (obs !== 6'b0 || kif.press_count !== 2'd0 || kif.dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state got obs=%b cnt=%0d st=%0d exp obs=000000 cnt=0 st=0",
                  obs, kif.press_count, kif.dbg_state);
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         n_cmp++;
         if (obs !== 6'b0 || kif.press_count !== 2'd0) begin
            n_fail++;
            $display("FAIL lockout_held cyc=%0d got obs=%b cnt=%0d exp obs=000000 cnt=0",
                     i, obs, kif.press_count);
         end
      end
      kif.key_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (obs !== 6'b0 || kif.press_count !== 2'd0) begin
            n_fail++;
            $display("FAIL lockout_low cyc=%0d got obs=%b cnt=%0d exp obs=000000 cnt=0",
                     i, obs, kif.press_count);
         end
      end
      kif.key_in = 1'b1;
      step();
      exp_v = P_PRESS | P_HELD;
      n_cmp++;
      if (obs !== exp_v || kif.press_count !== 2'd1) begin
         n_fail++;
         $display("FAIL first_press got obs=%b cnt=%0d exp obs=%b cnt=1", obs, kif.press_count, exp_v);
      end
      kif.key_in = 1'b0;
      step();
      exp_v = P_REL | P_CLICK;
      n_cmp++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL first_release got obs=%b exp obs=%b", obs, exp_v);
      end
      step();
   endtask

   // Holds the key for n_high sampled edges (E0..E(n_high-1)) and checks every cycle,
   // including the release edge and three quiet edges after it.
   task automatic test_hold(input string name, input int n_high);
      logic [5:0] exp_v;
      kif.key_in = 1'b1;
      for (int i = 0; i < n_high; i++) begin
         step();
         exp_v = P_HELD;
         if (i == 0) exp_v = exp_v | P_PRESS;
         if (i == 10) exp_v = exp_v | P_LONG;
         if (i > 10 && ((i - 10) % 4) == 0) exp_v = exp_v | P_REP;
         n_cmp++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s_hold E%0d got obs=%b exp obs=%b", name, i, obs, exp_v);
         end
      end
      kif.key_in = 1'b0;
      step();
      exp_v = (n_high > 10) ? P_REL : (P_REL | P_CLICK);
      n_cmp++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s_release E%0d got obs=%b exp obs=%b", name, n_high, obs, exp_v);
      end
      for (int i = 1; i <= 3; i++) begin
         step();
         n_cmp++;
         if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL %s_quiet E%0d got obs=%b exp obs=000000", name, n_high + i, obs);
         end
      end
   endtask

   task automatic test_counter();
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      kif.count_clr = 1'b1;
      step();
      kif.count_clr = 1'b0;
      n_cmp++;
      if (kif.press_count !== 2'd0) begin
         n_fail++;
         $display("FAIL clr_start got cnt=%0d exp cnt=0", kif.press_count);
      end
      for (int i = 0; i < 5; i++) begin
         kif.key_in = 1'b1;
         step();
         n_cmp++;
         if (kif.press_count !== exp_seq[i] || kif.press_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL count_seq n=%0d got cnt=%0d press=%b exp cnt=%0d press=1",
                     i, kif.press_count, kif.press_pulse, exp_seq[i]);
         end
         kif.key_in = 1'b0;
         step();
      end
      kif.count_clr = 1'b1;
      step();
      kif.count_clr = 1'b0;
      n_cmp++;
      if (kif.press_count !== 2'd0) begin
         n_fail++;
         $display("FAIL clr_alone got cnt=%0d exp cnt=0", kif.press_count);
      end
      step();
      kif.count_clr = 1'b1;
      step();
      kif.count_clr = 1'b0;
      kif.key_in = 1'b1;
      kif.count_clr = 1'b1;
      step();
      kif.count_clr = 1'b0;
      n_cmp++;
      if (kif.press_count !== 2'd1 || kif.press_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_with_press got cnt=%0d press=%b exp cnt=1 press=1",
                  kif.press_count, kif.press_pulse);
      end
      kif.key_in = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset_mid_hold();
      logic [5:0] exp_v;
      kif.key_in = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         exp_v = P_HELD;
         if (i == 0) exp_v = exp_v | P_PRESS;
         if (i == 10) exp_v = exp_v | P_LONG;
         n_cmp++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL mid_hold E%0d got obs=%b exp obs=%b", i, obs, exp_v);
         end
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++;
      if (obs !== 6'b0 || kif.press_count !== 2'd0) begin
         n_fail++;
         $display("FAIL mid_reset got obs=%b cnt=%0d exp obs=000000 cnt=0", obs, kif.press_count);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (obs !== 6'b0 || kif.press_count !== 2'd0) begin
            n_fail++;
            $display("FAIL post_reset_held cyc=%0d got obs=%b cnt=%0d exp obs=000000 cnt=0",
                     i, obs, kif.press_count);
         end
      end
      kif.key_in = 1'b0;
      step();
      kif.key_in = 1'b1;
      step();
      exp_v = P_PRESS | P_HELD;
      n_cmp++;
      if (obs !== exp_v || kif.press_count !== 2'd1) begin
         n_fail++;
         $display("FAIL post_reset_press got obs=%b cnt=%0d exp obs=%b cnt=1",
                  obs, kif.press_count, exp_v);
      end
      kif.key_in = 1'b0;
      step();
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      test_reset();
      test_hold("short5", 5);
      test_hold("long20", 20);
      test_hold("edge10", 10);
      test_hold("edge11", 11);
      test_counter();
      test_reset_mid_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
